// File: rtl/csa_sum_pipe.sv
// Two-stage pipelined N-operand adder: a carry-save reduction in S1, then a carry-propagate add in S2.
// Define CSA_ACCUM_EN to add the running accumulator and the in_acc input path.
module csa_sum_pipe #(
  parameter int N  = 10,
  parameter int W  = 8,
  parameter int SW = 12
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N*W-1:0]  in_ops,
  input  logic            in_acc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SW-1:0]   out_sum,
  output logic            out_co
);

  if (N < 3) begin : g_n_check
    $error("csa_sum_pipe: N must be at least 3");
  end
  if (SW < W + $clog2(N)) begin : g_sw_check
    $error("csa_sum_pipe: SW must be at least W + clog2(N)");
  end

  // Operands are zero-extended to SW+1 bits so that the top carry is never lost.
  logic [SW:0] op_ext [N];

  for (genvar gi = 0; gi < N; gi++) begin : g_ext
    assign op_ext[gi] = {{(SW + 1 - W){1'b0}}, in_ops[gi*W +: W]};
  end

  // Chain of 3:2 compressors; stage gi folds operand gi+2 into the running sum/carry pair.
  for (genvar gi = 0; gi < N - 2; gi++) begin : g_csa
    logic [SW:0] a;
    logic [SW:0] b;
    logic [SW:0] c;
    logic [SW:0] s;
    logic [SW:0] cy;
    if (gi == 0) begin : g_first
      assign a = op_ext[0];
      assign b = op_ext[1];
    end else begin : g_next
      assign a = g_csa[gi-1].s;
      assign b = g_csa[gi-1].cy;
    end
    assign c  = op_ext[gi+2];
    assign s  = a ^ b ^ c;
    assign cy = ((a & b) | (a & c) | (b & c)) << 1;
  end

  logic [SW:0] tree_sum;
  logic [SW:0] tree_carry;
  assign tree_sum   = g_csa[N-3].s;
  assign tree_carry = g_csa[N-3].cy;

  logic            s1_valid_q, s1_valid_d;
  logic [SW:0]     s1_sum_q, s1_sum_d;
  logic [SW:0]     s1_carry_q, s1_carry_d;
  logic            s2_valid_q, s2_valid_d;
  logic [SW-1:0]   out_sum_q, out_sum_d;
  logic            s2_adv;
  logic            xfer;
  logic            accept;
  logic [SW:0]     p;

`ifdef CSA_ACCUM_EN
  logic            s1_acc_q, s1_acc_d;
  logic [SW-1:0]   acc_q, acc_d;
  logic            out_co_q, out_co_d;

  assign p      = s1_sum_q + s1_carry_q + (s1_acc_q ? {1'b0, acc_q} : {(SW + 1){1'b0}});
  assign out_co = out_co_q;
`else
  logic            unused_in_acc;
  logic            unused_p_msb;

  assign p             = s1_sum_q + s1_carry_q;
  assign out_co        = 1'b0;
  assign unused_in_acc = in_acc;
  assign unused_p_msb  = p[SW];
`endif

  always_comb begin
    s2_adv     = !s2_valid_q | out_ready;
    xfer       = s1_valid_q & s2_adv;
    in_ready   = !s1_valid_q | s2_adv;
    accept     = in_valid & in_ready;

    s1_valid_d = accept | (s1_valid_q & ~xfer);
    s1_sum_d   = accept ? tree_sum : s1_sum_q;
    s1_carry_d = accept ? tree_carry : s1_carry_q;

    // A transfer on the same edge as a pop keeps S2 full with the new result.
    s2_valid_d = xfer | (s2_valid_q & ~out_ready);
    out_sum_d  = xfer ? p[SW-1:0] : out_sum_q;
`ifdef CSA_ACCUM_EN
    s1_acc_d   = accept ? in_acc : s1_acc_q;
    acc_d      = xfer ? p[SW-1:0] : acc_q;
    out_co_d   = xfer ? p[SW] : out_co_q;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_sum_q   <= '0;
      s1_carry_q <= '0;
      s2_valid_q <= 1'b0;
      out_sum_q  <= '0;
`ifdef CSA_ACCUM_EN
      s1_acc_q   <= 1'b0;
      acc_q      <= '0;
      out_co_q   <= 1'b0;
`endif
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_sum_q   <= s1_sum_d;
      s1_carry_q <= s1_carry_d;
      s2_valid_q <= s2_valid_d;
      out_sum_q  <= out_sum_d;
`ifdef CSA_ACCUM_EN
      s1_acc_q   <= s1_acc_d;
      acc_q      <= acc_d;
      out_co_q   <= out_co_d;
`endif
    end
  end

  assign out_valid = s2_valid_q;
  assign out_sum   = out_sum_q;

endmodule

// File: tb/tb_csa_sum_pipe.sv
// Randomised and directed bench for csa_sum_pipe against an arithmetic scoreboard model.
module tb_csa_sum_pipe;
  localparam int N  = 10;
  localparam int W  = 8;
  localparam int SW = 12;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_acc = 1'b0;
  logic           out_ready = 1'b0;
  logic [N*W-1:0] in_ops = '0;
  logic           in_ready;
  logic           out_valid;
  logic           out_co;
  logic [SW-1:0]  out_sum;

  int total = 0;
  int bad = 0;
  int acc_m = 0;
  logic [SW:0] exp_q[$];
  logic [SW:0] got_q[$];
  bit            hold_pend = 1'b0;
  logic [SW-1:0] hold_sum;
  logic          hold_co;

  always #5 clk = ~clk;

  csa_sum_pipe #(.N(N), .W(W), .SW(SW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_ops(in_ops), .in_acc(in_acc),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_co(out_co)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [N*W-1:0] mk(input int kind);
    logic [N*W-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) begin
      case (kind)
        0:       v[i*W +: W] = W'(i + 1);
        1:       v[i*W +: W] = (i < 2) ? '0 : W'(i + 1);
        default: v[i*W +: W] = '1;
      endcase
    end
    return v;
  endfunction

  task automatic model_push(input logic [N*W-1:0] ops, input logic a);
    int bsum;
    int tot;
    bsum = 0;
    for (int i = 0; i < N; i++) bsum += int'(ops[i*W +: W]);
`ifdef CSA_ACCUM_EN
    tot = (a ? acc_m : 0) + bsum;
`else
    tot = bsum + (a ? 0 : 0);
`endif
    acc_m = tot % (1 << SW);
    exp_q.push_back((SW + 1)'(tot));
  endtask

  // Drive one cycle of inputs at the falling edge, observe handshakes 1 ns later.
  task automatic step(input logic v, input logic [N*W-1:0] ops, input logic a, input logic r);
    logic [SW:0] e;
    in_valid = v; in_ops = ops; in_acc = a; out_ready = r;
    #1;
    if (hold_pend) begin
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_sum", 32'(out_sum), 32'(hold_sum));
      check("hold_co", 32'(out_co), 32'(hold_co));
    end
    hold_pend = out_valid && !out_ready;
    hold_sum  = out_sum;
    hold_co   = out_co;
    if (out_valid && out_ready) begin
      got_q.push_back({out_co, out_sum});
      if (exp_q.size() == 0) begin
        check("pop_unexpected", 32'(out_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("sb_sum", 32'(out_sum), 32'(e[SW-1:0]));
        check("sb_co", 32'(out_co), 32'(e[SW]));
      end
    end
    if (in_valid && in_ready) model_push(ops, a);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b1);
  endtask

  int exp_s[4];
  int exp_c[4];
  logic [N*W-1:0] rops;

  initial begin
`ifdef CSA_ACCUM_EN
    exp_s = '{55, 107, 2550, 1004};
    exp_c = '{0, 0, 0, 1};
`else
    exp_s = '{55, 52, 2550, 2550};
    exp_c = '{0, 0, 0, 0};
`endif
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_sum", 32'(out_sum), 32'd0);
    check("rst_co", 32'(out_co), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // two-cycle latency
    step(1'b1, mk(0), 1'b0, 1'b1);
    check("lat_edge1_valid", 32'(out_valid), 32'd0);
    step(1'b0, '0, 1'b0, 1'b1);
    check("lat_edge2_valid", 32'(out_valid), 32'd1);
    check("lat_sum", 32'(out_sum), 32'd55);
    check("lat_co", 32'(out_co), 32'd0);
    idle(1);

    // back-to-back, including accumulate beats
    got_q.delete();
    step(1'b1, mk(0), 1'b0, 1'b1);
    step(1'b1, mk(1), 1'b1, 1'b1);
    step(1'b1, mk(2), 1'b0, 1'b1);
    step(1'b1, mk(2), 1'b1, 1'b1);
    idle(2);
    check("b2b_count", 32'(got_q.size()), 32'd4);
    if (got_q.size() >= 4) begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("b2b_sum%0d", i), 32'(got_q[i][SW-1:0]), 32'(exp_s[i]));
        check($sformatf("b2b_co%0d", i), 32'(got_q[i][SW]), 32'(exp_c[i]));
      end
    end

    // backpressure
    got_q.delete();
    step(1'b1, mk(0), 1'b0, 1'b0);
    step(1'b1, mk(1), 1'b0, 1'b0);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    check("bp_valid", 32'(out_valid), 32'd1);
    check("bp_hold", 32'(out_sum), 32'd55);
    step(1'b1, mk(2), 1'b0, 1'b0);
    in_valid = 1'b1; in_ops = mk(2); out_ready = 1'b1;
    #1;
    check("bp_comb_ready", 32'(in_ready), 32'd1);
    step(1'b1, mk(2), 1'b0, 1'b1);
    idle(3);
    check("bp_count", 32'(got_q.size()), 32'd3);
    if (got_q.size() >= 3) begin
      check("bp_first", 32'(got_q[0][SW-1:0]), 32'd55);
      check("bp_second", 32'(got_q[1][SW-1:0]), 32'd52);
      check("bp_third", 32'(got_q[2][SW-1:0]), 32'd2550);
    end

    // asynchronous reset with both stages full
    step(1'b1, mk(0), 1'b0, 1'b0);
    step(1'b1, mk(1), 1'b0, 1'b0);
    check("mid_pre_valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_sum", 32'(out_sum), 32'd0);
    check("mid_rst_co", 32'(out_co), 32'd0);
    exp_q.delete();
    acc_m = 0;
    hold_pend = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_in_ready", 32'(in_ready), 32'd1);
    got_q.delete();
    step(1'b1, mk(0), 1'b1, 1'b1);
    idle(3);
    check("mid_count", 32'(got_q.size()), 32'd1);
    if (got_q.size() >= 1) check("mid_acc_cleared", 32'(got_q[0][SW-1:0]), 32'd55);

    // random traffic with random backpressure
    for (int k = 0; k < 500; k++) begin
      for (int i = 0; i < N; i++) rops[i*W +: W] = ($urandom_range(0, 7) == 0) ? '1 : W'($urandom);
      step(($urandom_range(0, 3) != 0), rops, 1'($urandom), ($urandom_range(0, 3) != 0));
    end
    idle(20);
    check("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
